ras_stack: RTL

- Parametrised return-address stack (RAS) for the pipelined MIPS core.
- Sits beside the ID-stage branch/jump logic.
  - jal/jalr push the link address (PC+8).
  - `jr $31` pops it and predicts the return target.
- Generalises the single fixed link register ($31) to a configurable-depth circular stack, with overflow/underflow signalling and optional speculative checkpointing.

---
 rtl/ras_stack_if.sv | 56 +++++
 rtl/ras_stack.sv | 132 +++++++++++++
 2 files changed

// File: rtl/ras_stack_if.sv
// Bundles the call/return command and status signals of the return-address stack.
// Checkpoint signals exist only when RAS_CHECKPOINT_EN is defined.
interface ras_stack_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 8
);
   localparam int CNT_WIDTH = $clog2(DEPTH + 1);

   logic                  flush_i;
   logic                  push_i;
   logic [ADDR_WIDTH-1:0] push_addr_i;
   logic                  pop_i;
   logic [ADDR_WIDTH-1:0] top_o;
   logic                  valid_o;
   logic [CNT_WIDTH-1:0]  count_o;
   logic                  overflow_o;
   logic                  underflow_o;
`ifdef RAS_CHECKPOINT_EN
   logic                  ckpt_i;
   logic                  restore_i;
`endif

   // Commands are single-cycle strobes sampled on every rising edge; the stack
   // is always ready, so there is no back-pressure and no ready signal.
   modport master (
`ifdef RAS_CHECKPOINT_EN
      output ckpt_i,
      output restore_i,
`endif
      output flush_i,
      output push_i,
      output push_addr_i,
      output pop_i,
      input  top_o,
      input  valid_o,
      input  count_o,
      input  overflow_o,
      input  underflow_o
   );

   modport slave (
`ifdef RAS_CHECKPOINT_EN
      input  ckpt_i,
      input  restore_i,
`endif
      input  flush_i,
      input  push_i,
      input  push_addr_i,
      input  pop_i,
      output top_o,
      output valid_o,
      output count_o,
      output overflow_o,
      output underflow_o
   );
endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack for the ID-stage call/return predictor.
// Optional speculative checkpoint/restore of {ptr,count} is enabled by RAS_CHECKPOINT_EN.
module ras_stack #(
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
   input logic       clk,
   input logic       rst,
   ras_stack_if.slave bus
);
   localparam int CNT_WIDTH = $clog2(DEPTH + 1);
   localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

   logic [ADDR_WIDTH-1:0] mem [DEPTH];

   logic [PTR_WIDTH-1:0]  ptr_q;
   logic [PTR_WIDTH-1:0]  ptr_d;
   logic [CNT_WIDTH-1:0]  count_q;
   logic [CNT_WIDTH-1:0]  count_d;
   logic                  overflow_q;
   logic                  overflow_d;
   logic                  underflow_q;
   logic                  underflow_d;

   logic                  wr_en;
   logic [PTR_WIDTH-1:0]  wr_idx;
   logic [PTR_WIDTH-1:0]  top_idx;
   logic                  empty;
   logic                  full;

`ifdef RAS_CHECKPOINT_EN
   logic [PTR_WIDTH-1:0]  shadow_ptr_q;
   logic [CNT_WIDTH-1:0]  shadow_cnt_q;
`endif

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_FULL);
   // DEPTH is a power of two, so plain pointer arithmetic wraps modulo DEPTH.
   assign top_idx = ptr_q - PTR_ONE;

   always_comb begin
      ptr_d       = ptr_q;
      count_d     = count_q;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      wr_en       = 1'b0;
      wr_idx      = ptr_q;

      if (bus.flush_i) begin
         ptr_d   = '0;
         count_d = '0;
      end
`ifdef RAS_CHECKPOINT_EN
      else if (bus.restore_i) begin
         ptr_d   = shadow_ptr_q;
         count_d = shadow_cnt_q;
      end
`endif
      else if (bus.push_i && bus.pop_i) begin
         wr_en = 1'b1;
         if (empty) begin
            ptr_d       = ptr_q + PTR_ONE;
            count_d     = count_q + CNT_ONE;
            underflow_d = 1'b1;
         end else begin
            // Return immediately followed by a call: overwrite the top in place.
            wr_idx = top_idx;
         end
      end
      else if (bus.push_i) begin
         wr_en = 1'b1;
         ptr_d = ptr_q + PTR_ONE;
         if (full) begin
            overflow_d = 1'b1;
         end else begin
            count_d = count_q + CNT_ONE;
         end
      end
      else if (bus.pop_i) begin
         if (empty) begin
            underflow_d = 1'b1;
         end else begin
            ptr_d   = top_idx;
            count_d = count_q - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q       <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage needs no reset: empty entries are masked on top_o by count.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= bus.push_addr_i;
      end
   end

`ifdef RAS_CHECKPOINT_EN
   // Snapshot takes the post-update pointer so a call in the checkpoint cycle is kept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow_ptr_q <= '0;
         shadow_cnt_q <= '0;
      end else if (bus.ckpt_i) begin
         shadow_ptr_q <= ptr_d;
         shadow_cnt_q <= count_d;
      end
   end
`endif

   assign bus.top_o       = empty ? '0 : mem[top_idx];
   assign bus.valid_o     = !empty;
   assign bus.count_o     = count_q;
   assign bus.overflow_o  = overflow_q;
   assign bus.underflow_o = underflow_q;

endmodule
